// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the cpu_mc multi-cycle core.
//   - opcode and R-type func encodings
//   - HALT instruction word
//   - FSM state enum and ALU operation enum
// The ALU_MUL operation exists only when CPU_MUL_EN is defined.
package cpu_pkg;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_ADDI  = 3'b001;
  localparam logic [2:0] OP_LW    = 3'b010;
  localparam logic [2:0] OP_SW    = 3'b011;
  localparam logic [2:0] OP_BEQ   = 3'b100;
  localparam logic [2:0] OP_J     = 3'b101;
  localparam logic [2:0] OP_RSV   = 3'b110;
  localparam logic [2:0] OP_SYS   = 3'b111;

  localparam logic [3:0] FN_ADD = 4'd0;
  localparam logic [3:0] FN_SUB = 4'd1;
  localparam logic [3:0] FN_AND = 4'd2;
  localparam logic [3:0] FN_OR  = 4'd3;
  localparam logic [3:0] FN_XOR = 4'd4;
  localparam logic [3:0] FN_SLT = 4'd5;
  localparam logic [3:0] FN_SLL = 4'd6;
  localparam logic [3:0] FN_SRL = 4'd7;
  localparam logic [3:0] FN_MUL = 4'd8;

  localparam logic [15:0] INSN_HALT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_STOP
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_SLL,
    ALU_SRL
`ifdef CPU_MUL_EN
    , ALU_MUL
`endif
  } alu_op_t;

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational ALU for cpu_mc.
// Ports:
//   op   - operation select (alu_op_t)
//   a, b - operands, DATA_W bits
//   y    - result, modulo 2^DATA_W
//   zero - y == 0 (used for beq compare via subtract)
// Shifts use only b[3:0]. Multiply is present only with CPU_MUL_EN.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              zero
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLT: y = DATA_W'($signed(a) < $signed(b));
      ALU_SLL: y = a << b[3:0];
      ALU_SRL: y = a >> b[3:0];
`ifdef CPU_MUL_EN
      ALU_MUL: y = a * b;
`endif
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle 16-bit-instruction CPU with req/ack instruction and
// data memory ports.
// Parameters: DATA_W (>= 16) register/datapath width, ADDR_W (>= 13) PC and
// data-address width.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   imem_req/addr/ack/rdata  - instruction fetch handshake (addr = pc)
//   dmem_req/we/addr/wdata/ack/rdata - data access handshake
//   retire                   - one-cycle pulse per completed instruction
//   pc_out                   - architectural PC
//   halted, illegal          - core stopped; stop caused by illegal insn
// Build option: CPU_MUL_EN enables R-type func 8 (mul); otherwise illegal.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_FETCH | imem_req high until imem_ack; latch instruction
// ST_EXEC  | decode, ALU, effective address, next pc
// ST_MEM   | dmem_req high with stable request until dmem_ack
// ST_WB    | register write, pc update, retire pulse
// ST_STOP  | halted; left only by rst
module cpu_mc
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              retire,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted,
  output logic              illegal
);

  state_t            state;
  logic              run;   // low for the cycle after reset so imem_req starts at 0
  logic [ADDR_W-1:0] pc;
  logic [15:0]       ir;
  logic [DATA_W-1:0] regs [8];

  logic [DATA_W-1:0] wr_val;
  logic              wr_en;
  logic [2:0]        wr_dst;
  logic [ADDR_W-1:0] pc_nxt;

  logic [2:0]        op, rs_i, rt_i, rd_i;
  logic [3:0]        func;
  logic [DATA_W-1:0] rs_val, rt_val, simm_d;
  logic [ADDR_W-1:0] simm_a, ea, pc_inc, pc_nxt_d;

  alu_op_t           alu_op;
  logic [DATA_W-1:0] alu_b, alu_y;
  logic              alu_zero;
  logic              ill_d, halt_d, wr_en_d;
  logic [2:0]        wr_dst_d;

  assign op   = ir[15:13];
  assign rs_i = ir[12:10];
  assign rt_i = ir[9:7];
  assign rd_i = ir[6:4];
  assign func = ir[3:0];

  // r0 is never written and resets to 0, so a plain read returns 0
  assign rs_val = regs[rs_i];
  assign rt_val = regs[rt_i];
  assign simm_d = DATA_W'($signed(ir[6:0]));
  assign simm_a = ADDR_W'($signed(ir[6:0]));
  assign ea     = ADDR_W'(rs_val) + simm_a;
  assign pc_inc = pc + ADDR_W'(1);

  always_comb begin
    alu_op   = ALU_ADD;
    alu_b    = rt_val;
    ill_d    = 1'b0;
    halt_d   = 1'b0;
    wr_en_d  = 1'b0;
    wr_dst_d = rd_i;
    case (op)
      OP_RTYPE: begin
        wr_en_d = 1'b1;
        case (func)
          FN_ADD: alu_op = ALU_ADD;
          FN_SUB: alu_op = ALU_SUB;
          FN_AND: alu_op = ALU_AND;
          FN_OR:  alu_op = ALU_OR;
          FN_XOR: alu_op = ALU_XOR;
          FN_SLT: alu_op = ALU_SLT;
          FN_SLL: alu_op = ALU_SLL;
          FN_SRL: alu_op = ALU_SRL;
`ifdef CPU_MUL_EN
          FN_MUL: alu_op = ALU_MUL;
`endif
          default: begin
            ill_d   = 1'b1;
            wr_en_d = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        alu_b    = simm_d;
        wr_en_d  = 1'b1;
        wr_dst_d = rt_i;
      end
      OP_LW: begin
        wr_en_d  = 1'b1;
        wr_dst_d = rt_i;
      end
      OP_SW:  ;
      OP_BEQ: alu_op = ALU_SUB;
      OP_J:   ;
      OP_SYS: begin
        if (ir == INSN_HALT) halt_d = 1'b1;
        else                 ill_d  = 1'b1;
      end
      default: ill_d = 1'b1;
    endcase
  end

  always_comb begin
    pc_nxt_d = pc_inc;
    if (op == OP_BEQ && alu_zero) pc_nxt_d = pc_inc + simm_a;
    else if (op == OP_J)          pc_nxt_d = ADDR_W'(ir[12:0]);
  end

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op   (alu_op),
    .a    (rs_val),
    .b    (alu_b),
    .y    (alu_y),
    .zero (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_FETCH;
      run        <= 1'b0;
      pc         <= '0;
      ir         <= '0;
      wr_val     <= '0;
      wr_en      <= 1'b0;
      wr_dst     <= '0;
      pc_nxt     <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      illegal    <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      run <= 1'b1;
      case (state)
        ST_FETCH: begin
          if (imem_req && imem_ack) begin
            ir    <= imem_rdata;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          wr_val <= alu_y;
          wr_en  <= wr_en_d;
          wr_dst <= wr_dst_d;
          pc_nxt <= pc_nxt_d;
          if (ill_d || halt_d) begin
            illegal <= ill_d;
            state   <= ST_STOP;
          end else if (op == OP_LW || op == OP_SW) begin
            dmem_we    <= (op == OP_SW);
            dmem_addr  <= ea;
            dmem_wdata <= rt_val;
            state      <= ST_MEM;
          end else begin
            state <= ST_WB;
          end
        end
        ST_MEM: begin
          if (dmem_ack) begin
            if (!dmem_we) wr_val <= dmem_rdata;
            dmem_we <= 1'b0;
            state   <= ST_WB;
          end
        end
        ST_WB: begin
          if (wr_en && wr_dst != 3'd0) regs[wr_dst] <= wr_val;
          pc    <= pc_nxt;
          state <= ST_FETCH;
        end
        ST_STOP: ;
        default: state <= ST_FETCH;
      endcase
    end
  end

  assign imem_req  = run && (state == ST_FETCH);
  assign imem_addr = pc;
  assign dmem_req  = (state == ST_MEM);
  assign retire    = (state == ST_WB);
  assign halted    = (state == ST_STOP);
  assign pc_out    = pc;

endmodule

// File: tb/tb_cpu_mc.sv
module tb_cpu_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack;
  logic [15:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        retire, halted, illegal;
  logic [15:0] pc_out;

  cpu_mc #(.DATA_W(16), .ADDR_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .retire     (retire),
    .pc_out     (pc_out),
    .halted     (halted),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  // architectural reference model
  logic [15:0] mreg [8];
  logic [15:0] mpc;
  logic [15:0] dm [int];

  // expectations for the instruction being executed
  logic [15:0] e_pc, e_addr, e_wdata, e_rdata;
  bit          e_mem, e_we, e_stop, e_ill;

  bit noise = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc_r(input int fn, input int rd, input int rs, input int rt);
    return {3'b000, 3'(rs), 3'(rt), 3'(rd), 4'(fn)};
  endfunction

  function automatic logic [15:0] enc_i(input logic [2:0] op, input int rs, input int rt, input int imm);
    return {op, 3'(rs), 3'(rt), 7'(imm)};
  endfunction

  function automatic logic [15:0] enc_j(input int addr);
    return {3'b101, 13'(addr)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mreg[i] = 16'h0;
    mpc = 16'h0;
  endtask

  // ISA interpreter: computes what one instruction must do, then updates state
  task automatic model_step(input logic [15:0] w);
    logic [15:0] a, b, simm, res;
    int dest;
    bit wr;
    a = mreg[w[12:10]];
    b = mreg[w[9:7]];
    simm = 16'($signed(w[6:0]));
    e_mem = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_rdata = 0;
    e_stop = 0; e_ill = 0; wr = 0; dest = 0; res = 0;
    e_pc = mpc + 16'd1;
    case (w[15:13])
      3'b000: begin
        dest = int'(w[6:4]);
        wr = 1;
        case (w[3:0])
          4'd0: res = a + b;
          4'd1: res = a - b;
          4'd2: res = a & b;
          4'd3: res = a | b;
          4'd4: res = a ^ b;
          4'd5: res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
          4'd6: res = 16'((32'(a) * (32'd1 << b[3:0])) % 65536);
          4'd7: res = 16'(32'(a) / (32'd1 << b[3:0]));
`ifdef CPU_MUL_EN
          4'd8: res = 16'((64'(a) * 64'(b)) % 65536);
`endif
          default: begin e_stop = 1; e_ill = 1; wr = 0; end
        endcase
      end
      3'b001: begin dest = int'(w[9:7]); wr = 1; res = a + simm; end
      3'b010: begin
        e_mem = 1;
        e_addr = a + simm;
        if (!dm.exists(int'(e_addr))) dm[int'(e_addr)] = 16'($urandom);
        e_rdata = dm[int'(e_addr)];
        res = e_rdata;
        dest = int'(w[9:7]);
        wr = 1;
      end
      3'b011: begin
        e_mem = 1; e_we = 1;
        e_addr = a + simm;
        e_wdata = b;
        dm[int'(e_addr)] = b;
      end
      3'b100: if (a == b) e_pc = mpc + 16'd1 + simm;
      3'b101: e_pc = {3'b000, w[12:0]};
      3'b110: begin e_stop = 1; e_ill = 1; end
      default: begin e_stop = 1; e_ill = (w != 16'hFFFF); end
    endcase
    if (!e_stop) begin
      if (wr && dest != 0) mreg[dest] = res;
      mpc = e_pc;
    end
  endtask

  task automatic do_reset();
    rst = 1; imem_ack = 0; dmem_ack = 0; imem_rdata = 0; dmem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_retire", retire, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_dmem_wdata", dmem_wdata, 0);
    rst = 0;
    model_reset();
  endtask

  // Run one instruction through the DUT, acting as both memories.
  task automatic exec(input logic [15:0] w, input int iw, input int dw);
    logic [15:0] pc0;
    int cyc, iwc, dwc, lat;
    bit done;
    pc0 = mpc;
    model_step(w);
    lat = 3 + iw + (e_mem ? 1 + dw : 0);
    cyc = 0; iwc = 0; dwc = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      imem_ack   = noise & 1'($urandom);
      dmem_ack   = noise & 1'($urandom);
      imem_rdata = 16'($urandom);
      dmem_rdata = 16'($urandom);
      if (retire) begin
        done = 1;
        chk("outcome_retire", 1, e_stop ? 0 : 1);
        chk("latency", cyc, lat);
        chk("req_low_in_wb", {imem_req, dmem_req}, 0);
      end else if (halted) begin
        done = 1;
        chk("outcome_halt", 1, e_stop ? 1 : 0);
        chk("halt_latency", cyc, 3 + iw);
        chk("illegal_flag", illegal, e_ill);
        repeat (2) begin
          @(negedge clk);
          chk("stop_sticky", {halted, retire, imem_req, dmem_req}, 4'b1000);
        end
      end else if (imem_req) begin
        chk("imem_addr", imem_addr, pc0);
        chk("pc_out", pc_out, pc0);
        if (iwc == iw) begin
          imem_ack = 1; imem_rdata = w;
        end else begin
          imem_ack = 0; iwc++;
        end
      end else if (dmem_req) begin
        chk("dmem_expected", 1, e_mem);
        chk("dmem_we", dmem_we, e_we);
        chk("dmem_addr", dmem_addr, e_addr);
        if (e_we) chk("dmem_wdata", dmem_wdata, e_wdata);
        if (dwc == dw) begin
          dmem_ack = 1; dmem_rdata = e_rdata;
        end else begin
          dmem_ack = 0; dwc++;
        end
      end
    end
    if (!done) chk("timeout", 0, 1);
  endtask

  initial begin
    logic [15:0] w;
    int op, iw, dw;

    do_reset();

    // basic ALU sequence: r3 = 5 + -3
    exec(enc_i(3'b001, 0, 1, 5), 0, 0);
    exec(enc_i(3'b001, 0, 2, -3), 0, 0);
    exec(enc_r(0, 3, 1, 2), 0, 0);
    exec(enc_i(3'b011, 0, 3, 0), 0, 0);

    // store/load with two wait states each
    exec(enc_i(3'b011, 0, 1, 4), 0, 2);
    exec(enc_i(3'b010, 0, 4, 4), 0, 2);
    exec(enc_i(3'b011, 0, 4, 5), 1, 0);

    // branches and jump
    exec(enc_j(10), 0, 0);
    exec(enc_i(3'b100, 1, 1, -2), 0, 0);
    exec(enc_j(10), 0, 0);
    exec(enc_i(3'b100, 1, 2, -2), 0, 0);
    exec(enc_j(13'h1ABC), 0, 0);
    exec(enc_i(3'b011, 0, 0, 1), 0, 0);

    // slt and writes to r0
    exec(enc_r(5, 5, 2, 1), 0, 0);
    exec(enc_i(3'b011, 0, 5, 6), 0, 0);
    exec(enc_i(3'b001, 0, 0, 7), 0, 0);
    exec(enc_r(0, 0, 1, 1), 0, 0);
    exec(enc_i(3'b011, 0, 0, 7), 0, 0);

    // randomized legal instructions with wait states and stray acks
    noise = 1;
    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 5);
      iw = $urandom_range(0, 2);
      dw = $urandom_range(0, 2);
      if (op == 0)
        w = enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      else if (op == 5)
        w = enc_j($urandom_range(0, 8191));
      else
        w = enc_i(3'(op), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 127));
      exec(w, iw, dw);
    end
    noise = 0;

    // stops
    exec(enc_i(3'b110, 1, 2, 3), 0, 0);
    do_reset();
    exec(enc_i(3'b001, 0, 1, 9), 0, 0);
    exec(enc_i(3'b001, 0, 2, 6), 0, 0);
    exec(enc_r(8, 3, 1, 2), 1, 0);
`ifdef CPU_MUL_EN
    exec(enc_i(3'b011, 0, 3, 2), 0, 0);
`endif
    do_reset();
    exec(16'hFFFF, 0, 0);
    do_reset();
    exec(16'hE000, 0, 0);

    // reset during a waited load
    do_reset();
    exec(enc_i(3'b001, 0, 4, 3), 0, 0);
    w = enc_i(3'b010, 0, 4, 3);
    @(negedge clk);
    chk("abort_fetch_req", imem_req, 1);
    imem_ack = 1; imem_rdata = w;
    @(negedge clk);
    imem_ack = 0;
    @(negedge clk);
    chk("abort_dmem_req", dmem_req, 1);
    @(negedge clk);
    chk("abort_dmem_req_held", dmem_req, 1);
    rst = 1;
    @(negedge clk);
    chk("abort_dmem_drop", dmem_req, 0);
    chk("abort_no_retire", retire, 0);
    chk("abort_pc", pc_out, 0);
    dmem_ack = 1;
    rst = 0;
    model_reset();
    exec(enc_i(3'b011, 0, 4, 0), 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
